// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated multiplexer.
package arb_mux_pkg;

    localparam int MODE_SEL = 0;   // channel chosen by the external select
    localparam int MODE_RR  = 1;   // channel chosen by the round-robin arbiter

    // Index width for n channels; never narrower than one bit.
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_mux_nx1_rr_pick.sv
// Combinational round-robin search: first valid channel at or after ptr.
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_w(N)
) (
    input  logic [SELW-1:0] ptr,
    input  logic [N-1:0]    valid,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    logic w_hit;

    // Walk ptr, ptr+1, ..., wrapping past N-1; the first valid channel wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_hit       = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx         = (int'(ptr) + k) % N;
            w_hit       = !grant_valid && valid[idx];
            grant       = w_hit ? idx[SELW-1:0] : grant;
            grant_valid = grant_valid | valid[idx];
        end
    end

endmodule

// File: rtl/arb_mux_nx1.sv
// Registered N-to-1 multiplexer with valid/ready handshakes and a one-entry
// output buffer; channel chosen by external select or round-robin.
module arb_mux_nx1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL,
    parameter int SELW  = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_src;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_grant_valid;
    logic             w_xfer;
    logic [SELW-1:0]  w_grant;
    logic [WIDTH-1:0] w_grant_data;

    // Buffer can take a beat when empty or being drained this cycle.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_xfer    = w_load_en && w_grant_valid;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic w_unused_sel;
            assign w_unused_sel = ^sel;

            rr_pick #(
                .N    (N),
                .SELW (SELW)
            ) u_rr_pick (
                .ptr         (r_ptr),
                .valid       (in_valid),
                .grant       (w_grant),
                .grant_valid (w_grant_valid)
            );
        end else begin : g_sel
            logic w_unused_ptr;
            assign w_unused_ptr = ^r_ptr;

            // External select: only an in-range channel that is offering data is granted.
            always_comb begin
                w_grant       = sel;
                w_grant_valid = 1'b0;
                for (int i = 0; i < N; i++) begin
                    w_grant_valid = (int'(sel) == i) ? in_valid[i] : w_grant_valid;
                end
            end
        end
    endgenerate

    // Pick the granted channel's data word (loop keeps out-of-range indices harmless).
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            w_grant_data = (int'(w_grant) == i) ? in_data[i*WIDTH +: WIDTH] : w_grant_data;
        end
    end

    // One-hot accept strobe, forced low for the whole time reset is asserted.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && w_xfer && (int'(w_grant) == i);
        end
    end

    // Output buffer and round-robin pointer: load, drain or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_grant_data;
            r_out_src   <= w_grant;
            r_out_valid <= 1'b1;
            if (MODE == MODE_RR) begin
                r_ptr <= (int'(w_grant) == N - 1) ? '0 : w_grant + SELW'(1'b1);
            end else begin
                r_ptr <= '0;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Self-checking bench: three instances (N=4 select, N=4 round-robin,
// N=3 select) driven by directed tables/sequences and random stimulus,
// each compared against a behavioural model.
module tb_arb_mux_nx1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [127:0] a_data, b_data;
    logic [95:0]  c_data;
    logic [3:0]   a_vld, a_rdy, b_vld, b_rdy;
    logic [2:0]   c_vld, c_rdy;
    logic [1:0]   a_sel, b_sel, c_sel, a_src, b_src, c_src;
    logic         a_ordy, b_ordy, c_ordy, a_ov, b_ov, c_ov;
    logic [31:0]  a_od, b_od, c_od;

    arb_mux_nx1 #(.WIDTH(32), .N(4), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_vld), .in_ready(a_rdy),
        .sel(a_sel), .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy), .out_src(a_src));
    arb_mux_nx1 #(.WIDTH(32), .N(4), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_vld), .in_ready(b_rdy),
        .sel(b_sel), .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy), .out_src(b_src));
    arb_mux_nx1 #(.WIDTH(32), .N(3), .MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_vld), .in_ready(c_rdy),
        .sel(c_sel), .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy), .out_src(c_src));

    int n_chk = 0;
    int n_err = 0;

    // Abstract model state: buffer contents plus the next channel to favour.
    typedef struct {
        bit          v;
        logic [31:0] d;
        int          src;
        int          ptr;
    } mstate_t;

    mstate_t ma, mb, mc;

    typedef struct {
        logic [3:0]  vld;
        logic [1:0]  sel;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  src;
        logic [31:0] dat;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of the specification's rules for an n-channel block.
    function automatic void m_eval(input mstate_t s, input int n, input int mode,
                                   input logic [3:0] vld, input int sel, input bit ordy,
                                   input bit rst, input logic [127:0] dat,
                                   output logic [3:0] rdy, output mstate_t ns);
        bit load_en;
        bit gv;
        int g;
        load_en = !s.v || ordy;
        gv = 1'b0;
        g = 0;
        if (mode == 0) begin
            g  = sel;
            gv = (sel < n) && vld[sel];
        end else begin
            for (int k = 0; k < n; k++) begin
                if (!gv && vld[(s.ptr + k) % n]) begin
                    gv = 1'b1;
                    g  = (s.ptr + k) % n;
                end
            end
        end
        rdy = (rst && load_en && gv) ? 4'(1 << g) : 4'b0000;
        ns = s;
        if (!rst) begin
            ns.v = 1'b0; ns.d = 32'h0; ns.src = 0; ns.ptr = 0;
        end else if (load_en && gv) begin
            ns.v = 1'b1;
            ns.d = dat[g*32 +: 32];
            ns.src = g;
            ns.ptr = (mode == 1) ? (g + 1) % n : 0;
        end else if (s.v && ordy) begin
            ns.v = 1'b0;
        end
    endfunction

    // Check accept strobes, clock once, then check the registered outputs.
    task automatic step();
        logic [3:0] ra, rb, rc;
        mstate_t na, nb, nc;
        #1;
        m_eval(ma, 4, 0, a_vld, int'(a_sel), a_ordy, rst_n, a_data, ra, na);
        m_eval(mb, 4, 1, b_vld, int'(b_sel), b_ordy, rst_n, b_data, rb, nb);
        m_eval(mc, 3, 0, {1'b0, c_vld}, int'(c_sel), c_ordy, rst_n, {32'h0, c_data}, rc, nc);
        chk("a_in_ready", 32'(a_rdy), 32'(ra));
        chk("b_in_ready", 32'(b_rdy), 32'(rb));
        chk("c_in_ready", 32'(c_rdy), 32'(rc));
        @(posedge clk);
        ma = na; mb = nb; mc = nc;
        @(negedge clk);
        chk("a_out_valid", 32'(a_ov), 32'(ma.v));
        chk("a_out_src",   32'(a_src), 32'(ma.src));
        chk("a_out_data",  a_od, ma.d);
        chk("b_out_valid", 32'(b_ov), 32'(mb.v));
        chk("b_out_src",   32'(b_src), 32'(mb.src));
        chk("b_out_data",  b_od, mb.d);
        chk("c_out_valid", 32'(c_ov), 32'(mc.v));
        chk("c_out_src",   32'(c_src), 32'(mc.src));
        chk("c_out_data",  c_od, mc.d);
    endtask

    initial begin
        ma = '{1'b0, 32'h0, 0, 0};
        mb = '{1'b0, 32'h0, 0, 0};
        mc = '{1'b0, 32'h0, 0, 0};

        // Reset with every input offering data
        rst_n = 1'b0;
        a_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h0000_1111};
        b_data = {32'h0000_0013, 32'h0000_0012, 32'h0000_0011, 32'h0000_0010};
        c_data = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
        a_vld = 4'b1111; b_vld = 4'b1111; c_vld = 3'b111;
        a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
        a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_in_ready", {24'h0, a_rdy, b_rdy}, 32'h0);
            step();
            chk("rst_out_valid", {29'h0, a_ov, b_ov, c_ov}, 32'h0);
        end
        rst_n = 1'b1;
        a_vld = 4'b0000; b_vld = 4'b0000; c_vld = 3'b000;

        // External-select vectors: inputs, accept strobe, outputs after the edge
        tv[0] = '{4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEAD_BEEF};
        tv[1] = '{4'b0100, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hDEAD_BEEF};
        tv[2] = '{4'b1000, 2'd3, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h3333_3333};
        tv[3] = '{4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h3333_3333};
        tv[4] = '{4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_1111};
        tv[5] = '{4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0000_1111};
        for (int i = 0; i < 6; i++) begin
            a_vld = tv[i].vld; a_sel = tv[i].sel; a_ordy = tv[i].ordy;
            #1;
            chk("tbl_in_ready", 32'(a_rdy), 32'(tv[i].rdy));
            step();
            chk("tbl_out_valid", 32'(a_ov), 32'(tv[i].ov));
            chk("tbl_out_src", 32'(a_src), 32'(tv[i].src));
            chk("tbl_out_data", a_od, tv[i].dat);
        end

        // Round-robin fairness with all four channels valid
        b_vld = 4'b1111; b_ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_fair_src", 32'(b_src), 32'(k % 4));
            chk("rr_fair_data", b_od, 32'h10 + 32'(k % 4));
        end

        // Stall hold, then reload on the same edge the stall releases
        b_data[127:96] = 32'hA5A5_A5A5;
        b_vld = 4'b1000;
        step();
        chk("stall_load_src", 32'(b_src), 32'd3);
        b_vld = 4'b0001; b_ordy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_in_ready", 32'(b_rdy), 32'h0);
            step();
            chk("stall_hold_data", b_od, 32'hA5A5_A5A5);
            chk("stall_hold_src", {b_ov, 29'h0, b_src}, {1'b1, 29'h0, 2'd3});
        end
        b_ordy = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(b_rdy), 32'h1);
        step();
        chk("unstall_no_bubble", {b_ov, 29'h0, b_src}, {1'b1, 29'h0, 2'd0});

        // Pointer wrap: grant ch2 (pointer to 3), then ch0 and ch1 requesting
        b_vld = 4'b0100;
        step();
        chk("wrap_prep_src", 32'(b_src), 32'd2);
        b_vld = 4'b0011;
        #1;
        chk("wrap_rdy_ch0", 32'(b_rdy), 32'h1);
        step();
        chk("wrap_src_ch0", 32'(b_src), 32'd0);
        #1;
        chk("wrap_rdy_ch1", 32'(b_rdy), 32'h2);
        step();
        chk("wrap_src_ch1", 32'(b_src), 32'd1);

        // Three channels, select out of range makes no grant
        c_vld = 3'b111; c_sel = 2'd3;
        #1;
        chk("sel_oor_in_ready", 32'(c_rdy), 32'h0);
        step();
        chk("sel_oor_out_valid", 32'(c_ov), 32'h0);
        c_sel = 2'd2;
        #1;
        chk("sel2_in_ready", 32'(c_rdy), 32'h4);
        step();
        chk("sel2_out", {c_ov, 29'h0, c_src}, {1'b1, 29'h0, 2'd2});
        chk("sel2_data", c_od, 32'h0000_00C2);

        // Reset while stalled discards the beat and rewinds the pointer
        b_vld = 4'b0100; b_ordy = 1'b1;
        step();
        b_vld = 4'b0000; b_ordy = 1'b0;
        step();
        chk("midrst_pre_valid", 32'(b_ov), 32'h1);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(b_ov), 32'h0);
        rst_n = 1'b1;
        b_vld = 4'b1111; b_ordy = 1'b1;
        #1;
        chk("midrst_rdy_ch0", 32'(b_rdy), 32'h1);
        step();
        chk("midrst_src_ch0", 32'(b_src), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            a_data = {$urandom, $urandom, $urandom, $urandom};
            b_data = {$urandom, $urandom, $urandom, $urandom};
            c_data = {$urandom, $urandom, $urandom};
            a_vld  = 4'($urandom); b_vld = 4'($urandom); c_vld = 3'($urandom);
            a_sel  = 2'($urandom_range(0, 3));
            b_sel  = 2'($urandom_range(0, 3));
            c_sel  = 2'($urandom_range(0, 3));
            a_ordy = ($urandom_range(0, 3) != 0);
            b_ordy = ($urandom_range(0, 3) != 0);
            c_ordy = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/arb_mux_nx1.md
# arb_mux_nx1

Parametrised, registered N-to-1 multiplexer with valid/ready handshakes on every input and on the output. It selects one source channel per cycle, either by an external select or by an internal round-robin arbiter, and registers the result in a one-entry output buffer. It merges requesters such as a fetch port and a load/store port onto a single shared datapath port in the core.

## Interface
Parameters:
- WIDTH, 32: data width of each channel.
- N, 4: number of input channels, N ≥ 2.
- MODE, 0: 0 = external select (`sel`); 1 = round-robin arbitration, `sel` ignored.
- SELW (derived), clog2(N): index width.

Ports (the reset is synchronous and active-low):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i is offering data.
- in_ready  out  N  channel i is accepted this cycle; at most one bit is high.
- sel  in  SELW  channel index, used only when MODE=0.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  `out_data`/`out_src` hold a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_src  out  SELW  index of the channel that produced `out_data`.

## Operation
- **Reset.** While `rst_n`=0 at a clock edge, the block clears `out_valid`, `out_data`, `out_src` and the round-robin pointer `ptr` to 0. `in_ready` is all zeros for the whole time `rst_n` is low.
- **Load enable.** `load_en = !out_valid || out_ready`. The buffer can accept a new beat when it is empty or is being drained in the same cycle.
- **Grant in MODE 0.**
  - `grant = sel`, and the grant is valid only if `sel < N` and `in_valid[sel]`.
  - If `sel ≥ N` (N not a power of 2), no grant is made.
  - Any other valid inputs wait.
- **Grant in MODE 1.**
  - Search channels `ptr, ptr+1, …, N-1, 0, …, ptr-1` and grant the first one with `in_valid` high.
  - The grant is valid if any input is valid.
- **Accept.** `in_ready[i] = load_en && grant_valid && grant==i`. The accept is combinational from `in_valid`, `sel`, `out_valid`, `out_ready` and `ptr`.
- **Transfer.** On each edge with `load_en && grant_valid`: `out_data <= channel[grant]`, `out_src <= grant`, `out_valid <= 1`.
- **Pointer update (MODE 1).**
  - On each transfer, `ptr <= grant+1`, wrapping from N-1 to 0.
  - `ptr` is unchanged when nothing transfers.
  - In MODE 0, `ptr` stays 0.
- **Drain.** On an edge where `out_valid && out_ready && !(load_en && grant_valid)`, set `out_valid <= 0`.
- **Stall.** While `out_valid && !out_ready`, `out_data` and `out_src` are held stable and `in_ready` = 0.
- **Data-path rules.** No width conversion is done. Data passes bit-exact. `in_data` of channels that are not granted is ignored.

## Timing
- Latency: 1 cycle from input acceptance (`in_valid[i]&&in_ready[i]`) to `out_valid`.
- Throughput: one beat per cycle when `out_ready` is held high. Simultaneous drain and load keeps `out_valid`=1 with no bubble.
- There is no combinational path from `in_data` to `out_data`. `in_ready` depends combinationally on `out_ready`.
- **Fairness (MODE 1).** With all N inputs valid and `out_ready`=1, grants follow 0,1,…,N-1,0 and each channel is served once every N beats.
- **Pointer wrap.** With `ptr`=N-1 and only channel 0 valid, channel 0 is granted and `ptr` becomes 1.
- **Reset mid-operation.** A buffered beat is discarded. Inputs presented during reset are not accepted and must be re-offered.
- **Input protocol.** A source may drop `in_valid` before it is accepted; the block makes no assumption about input stability.

## Structure
- Shared package `arb_mux_pkg` holds:
  - the `MODE_SEL` = 0 and `MODE_RR` = 1 constants;
  - a `clog2`-based `SELW` helper function (minimum 1).
- One sub-module, `rr_pick`, is a natural split: a combinational priority search with inputs `ptr` and `valid[N-1:0]` and outputs `grant` and `grant_valid`. It is instantiated only when MODE=1, via a generate block.
- The top level holds the output buffer register, the `ptr` register and the `in_ready` decode.

## Test plan
- **Reset.** WIDTH=32, N=4. Hold `rst_n`=0 for 3 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_src`=0 and `in_ready`=0000 throughout.
- **MODE 0 select.**
  - `sel`=2, `in_valid`=0100, ch2=0xDEADBEEF, `out_ready`=1 → next cycle `out_data`=0xDEADBEEF, `out_src`=2.
  - With `sel`=1 and `in_valid`=0100 → `in_ready`=0000 and no transfer.
- **MODE 1 fairness.** All 4 valid (ch i = 0x10+i), `out_ready`=1 for 8 cycles → `out_src` sequence 0,1,2,3,0,1,2,3 and data 0x10..0x13 repeating.
- **Stall hold.** Load ch3=0xA5A5A5A5, then `out_ready`=0 for 4 cycles with ch0 valid → output is stable, `in_ready`=0000. When `out_ready` returns to 1, ch0 is loaded on the same edge with no bubble.
- **Round-robin wrap and skip (MODE 1).**
  - After a grant to ch2 (so `ptr`=3), present `in_valid`=0011 → ch0 is granted, then ch1.
  - N=3 with MODE 0 and `sel`=3 → no grant.
- **Reset mid-stall.** Hold `out_valid`=1 with `out_ready`=0, then assert `rst_n`=0 for 1 cycle → `out_valid`=0 and `ptr`=0; the next MODE 1 grant with all inputs valid goes to ch0.
